pattern_event_counter: RTL and testbench

Downstream consumer of the Mealy pattern detector's 2-bit code stream. Counts "110" detections (code 2) and "001" detections (code 1) over fixed windows of WINDOW valid samples. At the end of each window it emits a report (two counts plus flags) through a valid/ready handshake. Sits between the detector and the status/readout logic.

---
 rtl/pattern_event_counter.sv | 166 ++++++++++++++++
 tb/tb_pattern_event_counter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_event_counter.sv
// pattern_event_counter
// Counts "110" (code 2) and "001" (code 1) detections from the Mealy pattern
// detector over windows of WINDOW valid samples. It publishes one report per
// window through a valid/ready handshake. If a window ends while the previous
// report is still unconsumed, that window is dropped. The next report then
// carries an overrun flag to show that data was lost.
module pattern_event_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       code,
  input  logic             code_valid,
  input  logic             clear,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_cnt_hi,
  output logic [CNT_W-1:0] rpt_cnt_lo,
  output logic             rpt_err,
  output logic             rpt_overrun
);

  // A one-sample window still needs a one-bit counter, so the width never drops to zero
  localparam int SMP_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  state_e           state_q, state_d;

  logic [SMP_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] acc_hi_q, acc_hi_d;
  logic [CNT_W-1:0] acc_lo_q, acc_lo_d;
  logic             acc_err_q, acc_err_d;
  logic             drop_q, drop_d;

  logic [CNT_W-1:0] rpt_hi_q, rpt_hi_d;
  logic [CNT_W-1:0] rpt_lo_q, rpt_lo_d;
  logic             rpt_err_q, rpt_err_d;
  logic             rpt_ovr_q, rpt_ovr_d;

  logic             take;
  logic             end_win;
  logic [CNT_W-1:0] hi_final;
  logic [CNT_W-1:0] lo_final;
  logic             err_final;

  // Qualify this cycle's sample (clear discards it) and fold it into saturating window totals
  always_comb begin
    take      = code_valid & ~clear;
    end_win   = take && (smp_q == LAST_SMP);
    hi_final  = acc_hi_q;
    lo_final  = acc_lo_q;
    err_final = acc_err_q;
    if (code == 2'd2 && acc_hi_q != CNT_MAX) begin
      hi_final = acc_hi_q + CNT_W'(1);
    end
    if (code == 2'd1 && acc_lo_q != CNT_MAX) begin
      lo_final = acc_lo_q + CNT_W'(1);
    end
    if (code == 2'd3) begin
      err_final = 1'b1;
    end
  end

  // Window bookkeeping: clear or end of window restarts; invalid cycles hold everything
  always_comb begin
    smp_d     = smp_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    acc_err_d = acc_err_q;
    if (clear || end_win) begin
      smp_d     = '0;
      acc_hi_d  = '0;
      acc_lo_d  = '0;
      acc_err_d = 1'b0;
    end else if (code_valid) begin
      smp_d     = smp_q + SMP_W'(1);
      acc_hi_d  = hi_final;
      acc_lo_d  = lo_final;
      acc_err_d = err_final;
    end
  end

  // Window state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      smp_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      acc_err_q <= 1'b0;
    end else begin
      smp_q     <= smp_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      acc_err_q <= acc_err_d;
    end
  end

  // Report FSM: load on end of window when empty or being drained, otherwise drop and remember it
  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    rpt_hi_d  = rpt_hi_q;
    rpt_lo_d  = rpt_lo_q;
    rpt_err_d = rpt_err_q;
    rpt_ovr_d = rpt_ovr_q;
    unique case (state_q)
      EMPTY: begin
        if (end_win) begin
          rpt_hi_d  = hi_final;
          rpt_lo_d  = lo_final;
          rpt_err_d = err_final;
          rpt_ovr_d = drop_q;
          drop_d    = 1'b0;
          state_d   = FULL;
        end
      end
      FULL: begin
        if (end_win && rpt_ready) begin
          rpt_hi_d  = hi_final;
          rpt_lo_d  = lo_final;
          rpt_err_d = err_final;
          rpt_ovr_d = drop_q;
          drop_d    = 1'b0;
        end else if (rpt_ready) begin
          state_d = EMPTY;
        end else if (end_win) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Report state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      drop_q    <= 1'b0;
      rpt_hi_q  <= '0;
      rpt_lo_q  <= '0;
      rpt_err_q <= 1'b0;
      rpt_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      rpt_hi_q  <= rpt_hi_d;
      rpt_lo_q  <= rpt_lo_d;
      rpt_err_q <= rpt_err_d;
      rpt_ovr_q <= rpt_ovr_d;
    end
  end

  assign rpt_valid   = (state_q == FULL);
  assign rpt_cnt_hi  = rpt_hi_q;
  assign rpt_cnt_lo  = rpt_lo_q;
  assign rpt_err     = rpt_err_q;
  assign rpt_overrun = rpt_ovr_q;

endmodule

// File: tb/tb_pattern_event_counter.sv
// Testbench for pattern_event_counter. Two instances are used: a WINDOW=4 unit
// for the main scenarios and a WINDOW=8, CNT_W=2 unit for saturation. Stimulus
// pushes hand-computed reports into queues, and independent monitors pop them
// and compare whenever a report is presented.
module tb_pattern_event_counter;

  typedef struct {
    int hi;
    int lo;
    int err;
    int ov;
    int due;
  } expT;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;

  logic [1:0] code = 2'd0;
  logic       codeValid = 1'b0;
  logic       clear = 1'b0;
  logic       rptReady = 1'b0;
  logic       rptValid;
  logic [4:0] rptCntHi;
  logic [4:0] rptCntLo;
  logic       rptErr;
  logic       rptOverrun;

  logic [1:0] codeB = 2'd0;
  logic       codeValidB = 1'b0;
  logic       rptValidB;
  logic [1:0] rptCntHiB;
  logic [1:0] rptCntLoB;
  logic       rptErrB;
  logic       rptOverrunB;

  int  testsRun = 0;
  int  failures = 0;
  int  cycleCount = 0;
  bit  frontSeen = 0;
  expT expQ[$];
  expT expQB[$];

  pattern_event_counter #(.WINDOW(4), .CNT_W(5)) dut (
    .clock      (clock),
    .reset_n    (resetN),
    .code       (code),
    .code_valid (codeValid),
    .clear      (clear),
    .rpt_valid  (rptValid),
    .rpt_ready  (rptReady),
    .rpt_cnt_hi (rptCntHi),
    .rpt_cnt_lo (rptCntLo),
    .rpt_err    (rptErr),
    .rpt_overrun(rptOverrun)
  );

  pattern_event_counter #(.WINDOW(8), .CNT_W(2)) dutSat (
    .clock      (clock),
    .reset_n    (resetN),
    .code       (codeB),
    .code_valid (codeValidB),
    .clear      (1'b0),
    .rpt_valid  (rptValidB),
    .rpt_ready  (1'b1),
    .rpt_cnt_hi (rptCntHiB),
    .rpt_cnt_lo (rptCntLoB),
    .rpt_err    (rptErrB),
    .rpt_overrun(rptOverrunB)
  );

  // Free-running clock with a 10-unit period
  always #5 clock = ~clock;

  // Cycle counter used to check report latency
  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Safety net so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  task automatic pushExp(input int hi, input int lo, input int err, input int ov, input int due);
    expT e;
    e.hi = hi; e.lo = lo; e.err = err; e.ov = ov; e.due = due;
    expQ.push_back(e);
  endtask

  // Drive one cycle of inputs to the main unit, then return inputs to idle
  task automatic applyStimulus(input logic [1:0] c, input logic v, input logic clr);
    code = c; codeValid = v; clear = clr;
    @(posedge clock); #1;
    code = 2'd0; codeValid = 1'b0; clear = 1'b0;
  endtask

  // Feed one four-sample window; optionally expect a report and pulse ready on the last sample
  task automatic sendWindow(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                            input logic [1:0] c3, input int hi, input int lo, input int err,
                            input int ov, input bit expectRpt, input bit readyOnLast);
    applyStimulus(c0, 1'b1, 1'b0);
    applyStimulus(c1, 1'b1, 1'b0);
    applyStimulus(c2, 1'b1, 1'b0);
    if (expectRpt) pushExp(hi, lo, err, ov, cycleCount + 1);
    if (readyOnLast) rptReady = 1'b1;
    applyStimulus(c3, 1'b1, 1'b0);
    if (readyOnLast) rptReady = 1'b0;
  endtask

  // Monitor for the main unit: compare the presented report each cycle, pop on handshake
  always @(negedge clock) begin
    if (resetN && rptValid) begin
      if (expQ.size() == 0) begin
        testsRun++;
        failures++;
        $display("[TB] FAIL unexpected report: got rpt_valid 1 (hi %0d lo %0d), expected 0 at cycle %0d",
                 rptCntHi, rptCntLo, cycleCount);
      end else begin
        if (!frontSeen) begin
          checkOutput("latency cycle", cycleCount, expQ[0].due);
          frontSeen = 1;
        end
        checkOutput("rpt_cnt_hi", int'(rptCntHi), expQ[0].hi);
        checkOutput("rpt_cnt_lo", int'(rptCntLo), expQ[0].lo);
        checkOutput("rpt_err", int'(rptErr), expQ[0].err);
        checkOutput("rpt_overrun", int'(rptOverrun), expQ[0].ov);
        if (rptReady) begin
          expQ.delete(0);
          frontSeen = 0;
        end
      end
    end
  end

  // Monitor for the saturation unit, which always has ready asserted
  always @(negedge clock) begin
    if (resetN && rptValidB) begin
      if (expQB.size() == 0) begin
        testsRun++;
        failures++;
        $display("[TB] FAIL unexpected sat report: got rpt_valid 1, expected 0 at cycle %0d", cycleCount);
      end else begin
        checkOutput("sat rpt_cnt_hi", int'(rptCntHiB), expQB[0].hi);
        checkOutput("sat rpt_cnt_lo", int'(rptCntLoB), expQB[0].lo);
        checkOutput("sat rpt_err", int'(rptErrB), expQB[0].err);
        checkOutput("sat rpt_overrun", int'(rptOverrunB), expQB[0].ov);
        expQB.delete(0);
      end
    end
  end

  // Directed scenario sequence
  initial begin
    expT e;
    logic [1:0] satCodes [8];

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset rpt_valid", int'(rptValid), 0);
    checkOutput("reset rpt_cnt_hi", int'(rptCntHi), 0);
    checkOutput("reset rpt_cnt_lo", int'(rptCntLo), 0);
    checkOutput("reset rpt_err", int'(rptErr), 0);
    checkOutput("reset rpt_overrun", int'(rptOverrun), 0);
    resetN = 1'b1;

    // Basic window with ready held high
    rptReady = 1'b1;
    sendWindow(2'd2, 2'd0, 2'd1, 2'd2, 2, 1, 0, 0, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);

    // Same codes with gap cycles between them
    applyStimulus(2'd2, 1'b1, 1'b0);
    applyStimulus(2'd3, 1'b0, 1'b0);
    applyStimulus(2'd0, 1'b1, 1'b0);
    applyStimulus(2'd2, 1'b0, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);
    applyStimulus(2'd1, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);
    pushExp(2, 1, 0, 0, cycleCount + 1);
    applyStimulus(2'd2, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);

    // Window containing an illegal code
    sendWindow(2'd3, 2'd2, 2'd1, 2'd0, 1, 1, 1, 0, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);

    // Backpressure: first report held while two more windows are dropped
    rptReady = 1'b0;
    sendWindow(2'd1, 2'd1, 2'd1, 2'd1, 0, 4, 0, 0, 1'b1, 1'b0);
    sendWindow(2'd2, 2'd2, 2'd2, 2'd2, 0, 0, 0, 0, 1'b0, 1'b0);
    sendWindow(2'd3, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);
    rptReady = 1'b1;
    applyStimulus(2'd0, 1'b0, 1'b0);
    rptReady = 1'b0;
    sendWindow(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);

    // Handshake coincides with the end of the next window: report replaced in place
    sendWindow(2'd2, 2'd2, 2'd1, 2'd3, 2, 1, 1, 0, 1'b1, 1'b1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    rptReady = 1'b1;
    applyStimulus(2'd0, 1'b0, 1'b0);

    // Clear after two code-2 samples (the clear cycle's own sample is discarded)
    applyStimulus(2'd2, 1'b1, 1'b0);
    applyStimulus(2'd2, 1'b1, 1'b0);
    applyStimulus(2'd2, 1'b1, 1'b1);
    sendWindow(2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);

    // Clear wins over an end of window in the same cycle
    applyStimulus(2'd1, 1'b1, 1'b0);
    applyStimulus(2'd1, 1'b1, 1'b0);
    applyStimulus(2'd1, 1'b1, 1'b0);
    applyStimulus(2'd1, 1'b1, 1'b1);
    sendWindow(2'd2, 2'd1, 2'd0, 2'd0, 1, 1, 0, 0, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);

    // Asynchronous reset while a report is pending and a window is half full
    rptReady = 1'b0;
    sendWindow(2'd1, 2'd2, 2'd2, 2'd0, 2, 1, 0, 0, 1'b1, 1'b0);
    applyStimulus(2'd2, 1'b1, 1'b0);
    applyStimulus(2'd2, 1'b1, 1'b0);
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("async reset rpt_valid", int'(rptValid), 0);
    checkOutput("async reset rpt_cnt_hi", int'(rptCntHi), 0);
    checkOutput("async reset rpt_cnt_lo", int'(rptCntLo), 0);
    checkOutput("async reset rpt_err", int'(rptErr), 0);
    checkOutput("async reset rpt_overrun", int'(rptOverrun), 0);
    expQ.delete();
    frontSeen = 0;
    @(posedge clock); #1;
    resetN = 1'b1;
    rptReady = 1'b1;
    sendWindow(2'd0, 2'd1, 2'd0, 2'd0, 0, 1, 0, 0, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0);

    // Saturation unit: eight code-2 samples, then a mixed window
    e.hi = 3; e.lo = 0; e.err = 0; e.ov = 0; e.due = 0;
    expQB.push_back(e);
    for (int i = 0; i < 8; i++) begin
      codeB = 2'd2; codeValidB = 1'b1;
      @(posedge clock); #1;
    end
    satCodes = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    e.hi = 1; e.lo = 3; e.err = 1; e.ov = 0;
    expQB.push_back(e);
    for (int i = 0; i < 8; i++) begin
      codeB = satCodes[i]; codeValidB = 1'b1;
      @(posedge clock); #1;
    end
    codeB = 2'd0; codeValidB = 1'b0;

    // Bounded drain: every expected report must have been seen
    for (int i = 0; i < 20 && (expQ.size() != 0 || expQB.size() != 0); i++) begin
      @(posedge clock); #1;
    end
    checkOutput("main queue drained", expQ.size(), 0);
    checkOutput("sat queue drained", expQB.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
